// File: rtl/tl_ul_master_slave_if.sv
// A/D channel bundle between the load/store subsystem and the fabric that observes and throttles it.
// master: subsystem side driving both channels; slave: fabric side granting through a_ready/d_ready.
interface tl_ul_master_slave_if #(
  parameter int A_W = 53,
  parameter int D_W = 43
);
  logic           a_valid;
  logic           a_ready;
  logic [A_W-1:0] a_channel;
  logic           d_valid;
  logic           d_ready;
  logic [D_W-1:0] d_channel;
  logic           d_error;
  logic           backpressureslave;

  modport master (
    output a_valid, a_channel, d_valid, d_channel, d_error, backpressureslave,
    input  a_ready, d_ready
  );

  modport slave (
    input  a_valid, a_channel, d_valid, d_channel, d_error, backpressureslave,
    output a_ready, d_ready
  );
endinterface

// File: rtl/tl_ul_master_slave.sv
// TileLink-UL style subsystem: a load/store master issuing Get/PutFullData to a 64x32 word memory slave.
// One transaction is outstanding at a time; both channel buses are exported for observation/throttling.
module tl_ul_master_slave #(
  parameter int A_W       = 53,
  parameter int D_W       = 43,
  parameter int MEM_WORDS = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [31:0]                ir34,
  input  logic [31:0]                z4_input,
  input  logic [31:0]                md4_input,
  tl_ul_master_slave_if.master       bus,
  output logic [31:0]                rd_data,
  output logic                       rd_valid
);
  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [2:0] A_PUT      = 3'd0;
  localparam logic [2:0] A_GET      = 3'd4;
  localparam logic [2:0] D_ACK      = 3'd0;
  localparam logic [2:0] D_ACK_DATA = 3'd1;

  typedef enum logic [1:0] {M_IDLE = 2'd0, M_REQ = 2'd1, M_WAIT = 2'd2} m_state_t;
  typedef enum logic {S_READY = 1'b0, S_RESP = 1'b1} s_state_t;

  m_state_t       m_state_r, m_state_next_s;
  s_state_t       s_state_r, s_state_next_s;
  logic [A_W-1:0] a_channel_r;
  logic [D_W-1:0] d_channel_r;
  logic           a_valid_r, d_valid_r, d_error_r, bp_r, rd_valid_r;
  logic [31:0]    rd_data_r;
  logic [31:0]    mem_r [MEM_WORDS];

  logic           is_store_s, is_load_s, a_hs_s, d_hs_s;
  logic [2:0]     req_opcode_s, rsp_opcode_s;
  logic [7:0]     req_addr_s;
  logic [31:0]    req_data_s, rsp_data_s;
  logic [IDX_W-1:0] req_idx_s;
  logic           in_range_s, rsp_denied_s, wr_en_s;
  logic           unused_s;

  assign is_store_s   = (ir34[6:0] == OPC_STORE);
  assign is_load_s    = (ir34[6:0] == OPC_LOAD);
  assign a_hs_s       = a_valid_r & bus.a_ready & ~bp_r;
  assign d_hs_s       = d_valid_r & bus.d_ready;
  assign req_opcode_s = a_channel_r[52:50];
  assign req_addr_s   = a_channel_r[43:36];
  assign req_data_s   = a_channel_r[31:0];
  assign req_idx_s    = req_addr_s[IDX_W-1:0];
  assign in_range_s   = (req_addr_s[7:IDX_W] == '0);
  assign unused_s     = ^{ir34[31:7], z4_input[31:8], a_channel_r[49:44], a_channel_r[35:32], d_channel_r[39:32]};

  // Master next-state: issue on a load/store, wait for A grant, then for the response
  always_comb begin
    m_state_next_s = m_state_r;
    case (m_state_r)
      M_IDLE:  if (is_store_s || is_load_s) m_state_next_s = M_REQ;  else m_state_next_s = M_IDLE;
      M_REQ:   if (a_hs_s)                  m_state_next_s = M_WAIT; else m_state_next_s = M_REQ;
      M_WAIT:  if (d_hs_s)                  m_state_next_s = M_IDLE; else m_state_next_s = M_WAIT;
      default: m_state_next_s = M_IDLE;
    endcase
  end

  // Master state, A beat capture and load writeback
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_state_r   <= M_IDLE;
      a_valid_r   <= 1'b0;
      a_channel_r <= '0;
      rd_data_r   <= 32'd0;
      rd_valid_r  <= 1'b0;
    end else begin
      m_state_r  <= m_state_next_s;
      a_valid_r  <= (m_state_next_s == M_REQ);
      rd_valid_r <= 1'b0;
      if (m_state_r == M_IDLE && (is_store_s || is_load_s)) begin
        a_channel_r <= {(is_store_s ? A_PUT : A_GET), 3'd0, 2'd2, 1'b0, z4_input[7:0], 4'hF,
                        (is_store_s ? md4_input : 32'd0)};
      end
      if (m_state_r == M_WAIT && d_hs_s && d_channel_r[42:40] == D_ACK_DATA) begin
        rd_data_r  <= d_channel_r[31:0];
        rd_valid_r <= 1'b1;
      end
    end
  end

  // Slave request decode; anything out of range or with an unknown opcode is denied with zero data
  always_comb begin
    rsp_opcode_s = D_ACK;
    rsp_denied_s = 1'b1;
    rsp_data_s   = 32'd0;
    wr_en_s      = 1'b0;
    case (req_opcode_s)
      A_PUT: begin
        rsp_opcode_s = D_ACK;
        if (in_range_s) begin
          rsp_denied_s = 1'b0;
          wr_en_s      = a_hs_s;
        end else begin
          rsp_denied_s = 1'b1;
        end
      end
      A_GET: begin
        rsp_opcode_s = D_ACK_DATA;
        if (in_range_s) begin
          rsp_denied_s = 1'b0;
          rsp_data_s   = mem_r[req_idx_s];
        end else begin
          rsp_denied_s = 1'b1;
        end
      end
      default: rsp_denied_s = 1'b1;
    endcase
  end

  // Slave next-state: busy from A handshake until the response is consumed
  always_comb begin
    s_state_next_s = s_state_r;
    case (s_state_r)
      S_READY: if (a_hs_s) s_state_next_s = S_RESP;  else s_state_next_s = S_READY;
      S_RESP:  if (d_hs_s) s_state_next_s = S_READY; else s_state_next_s = S_RESP;
      default: s_state_next_s = S_READY;
    endcase
  end

  // Slave state and registered D response
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_state_r   <= S_READY;
      bp_r        <= 1'b0;
      d_valid_r   <= 1'b0;
      d_error_r   <= 1'b0;
      d_channel_r <= '0;
    end else begin
      s_state_r <= s_state_next_s;
      bp_r      <= (s_state_next_s == S_RESP);
      d_valid_r <= (s_state_next_s == S_RESP);
      if (a_hs_s) begin
        d_channel_r <= {rsp_opcode_s, 2'd0, 2'd2, 1'b0, 1'b0, rsp_denied_s, 1'b0, rsp_data_s};
        d_error_r   <= rsp_denied_s;
      end else if (d_hs_s) begin
        d_error_r <= 1'b0;
      end
    end
  end

  // Memory array, cleared on reset and written on an accepted in-range PutFullData
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < MEM_WORDS; i++) mem_r[i] <= 32'd0;
    end else if (wr_en_s) begin
      mem_r[req_idx_s] <= req_data_s;
    end
  end

  assign bus.a_valid           = a_valid_r;
  assign bus.a_channel         = a_channel_r;
  assign bus.d_valid           = d_valid_r;
  assign bus.d_channel         = d_channel_r;
  assign bus.d_error           = d_error_r;
  assign bus.backpressureslave = bp_r;
  assign rd_data               = rd_data_r;
  assign rd_valid              = rd_valid_r;
endmodule

// File: tb/tb_tl_ul_master_slave.sv
// Directed bench for tl_ul_master_slave: scenario tasks with hand-computed A/D beats.
module tb_tl_ul_master_slave;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] ir34 = 32'd0, z4 = 32'd0, md4 = 32'd0;
  logic [31:0] rd_data;
  logic        rd_valid;
  int          checks = 0;
  int          errors = 0;

  tl_ul_master_slave_if bus ();

  tl_ul_master_slave dut (
    .clk(clk), .reset(reset), .ir34(ir34), .z4_input(z4), .md4_input(md4),
    .bus(bus), .rd_data(rd_data), .rd_valid(rd_valid)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] ST = 7'b0100011;
  localparam logic [6:0] LD = 7'b0000011;

  function automatic logic [52:0] a_beat(input logic [2:0] op, input logic [7:0] addr, input logic [31:0] data);
    return {op, 3'd0, 2'd2, 1'b0, addr, 4'hF, data};
  endfunction

  function automatic logic [42:0] d_beat(input logic [2:0] op, input logic denied, input logic [31:0] data);
    return {op, 2'd0, 2'd2, 1'b0, 1'b0, denied, 1'b0, data};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // present one instruction for a single IDLE sample, then remove it
  task automatic issue(input logic [6:0] opc, input logic [31:0] addr, input logic [31:0] data);
    ir34 = {25'd0, opc};
    z4   = addr;
    md4  = data;
    tick();
    ir34 = 32'd0;
  endtask

  task automatic wait_d(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.d_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.a_ready = 1'b1;
    bus.d_ready = 1'b1;
    tick();
    tick();
    checks++;
    if ({bus.a_valid, bus.d_valid, bus.d_error, bus.backpressureslave, rd_valid} !== 5'b0) begin
      errors++; $display("FAIL reset_flags got %b want 00000", {bus.a_valid, bus.d_valid, bus.d_error, bus.backpressureslave, rd_valid});
    end
    checks++;
    if (bus.a_channel !== 53'd0 || bus.d_channel !== 43'd0 || rd_data !== 32'd0) begin
      errors++; $display("FAIL reset_buses got a=%h d=%h rd=%h want 0", bus.a_channel, bus.d_channel, rd_data);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_store_load();
    issue(ST, 32'd10, 32'd20);
    checks++;
    if (bus.a_valid !== 1'b1 || bus.a_channel !== a_beat(3'd0, 8'd10, 32'd20)) begin
      errors++; $display("FAIL store_a_beat got v=%b %h want v=1 %h", bus.a_valid, bus.a_channel, a_beat(3'd0, 8'd10, 32'd20));
    end
    tick();
    checks++;
    if (bus.a_valid !== 1'b0 || bus.d_valid !== 1'b1 || bus.backpressureslave !== 1'b1 || bus.d_error !== 1'b0 ||
        bus.d_channel !== d_beat(3'd0, 1'b0, 32'd0)) begin
      errors++; $display("FAIL store_ack got av=%b dv=%b bp=%b err=%b d=%h want 0 1 1 0 %h",
                         bus.a_valid, bus.d_valid, bus.backpressureslave, bus.d_error, bus.d_channel, d_beat(3'd0, 1'b0, 32'd0));
    end
    tick();
    checks++;
    if (bus.d_valid !== 1'b0 || bus.backpressureslave !== 1'b0 || rd_valid !== 1'b0) begin
      errors++; $display("FAIL store_done got dv=%b bp=%b rdv=%b want 0 0 0", bus.d_valid, bus.backpressureslave, rd_valid);
    end
    issue(LD, 32'd10, 32'd0);
    checks++;
    if (bus.a_channel !== a_beat(3'd4, 8'd10, 32'd0)) begin
      errors++; $display("FAIL load_a_beat got %h want %h", bus.a_channel, a_beat(3'd4, 8'd10, 32'd0));
    end
    tick();
    checks++;
    if (bus.d_valid !== 1'b1 || bus.d_channel !== d_beat(3'd1, 1'b0, 32'd20)) begin
      errors++; $display("FAIL load_ack_data got v=%b %h want v=1 %h", bus.d_valid, bus.d_channel, d_beat(3'd1, 1'b0, 32'd20));
    end
    tick();
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 32'd20) begin
      errors++; $display("FAIL load_rd got v=%b data=%0d want v=1 data=20", rd_valid, rd_data);
    end
    tick();
    checks++;
    if (rd_valid !== 1'b0) begin
      errors++; $display("FAIL rd_pulse got %b want 0", rd_valid);
    end
  endtask

  task automatic test_overwrite();
    bit ok;
    issue(ST, 32'd10, 32'd30);
    wait_d(ok);
    tick();
    issue(LD, 32'd10, 32'd0);
    wait_d(ok);
    checks++;
    if (!ok || bus.d_channel !== d_beat(3'd1, 1'b0, 32'd30)) begin
      errors++; $display("FAIL overwrite got ok=%b %h want ok=1 %h", ok, bus.d_channel, d_beat(3'd1, 1'b0, 32'd30));
    end
    tick();
  endtask

  task automatic test_d_stall();
    bit ok;
    bus.d_ready = 1'b0;
    issue(ST, 32'd3, 32'd55);
    wait_d(ok);
    ir34 = {25'd0, ST};
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (!ok || bus.d_valid !== 1'b1 || bus.backpressureslave !== 1'b1 || bus.a_valid !== 1'b0 ||
        bus.d_channel !== d_beat(3'd0, 1'b0, 32'd0)) begin
      errors++; $display("FAIL d_stall_hold got ok=%b dv=%b bp=%b av=%b d=%h want 1 1 1 0 %h",
                         ok, bus.d_valid, bus.backpressureslave, bus.a_valid, bus.d_channel, d_beat(3'd0, 1'b0, 32'd0));
    end
    ir34 = 32'd0;
    bus.d_ready = 1'b1;
    tick();
    checks++;
    if (bus.d_valid !== 1'b0 || bus.backpressureslave !== 1'b0) begin
      errors++; $display("FAIL d_stall_release got dv=%b bp=%b want 0 0", bus.d_valid, bus.backpressureslave);
    end
    tick();
  endtask

  task automatic test_a_stall();
    bit ok;
    bus.a_ready = 1'b0;
    issue(ST, 32'd12, 32'd77);
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (bus.a_valid !== 1'b1 || bus.a_channel !== a_beat(3'd0, 8'd12, 32'd77) || bus.d_valid !== 1'b0 || bus.backpressureslave !== 1'b0) begin
      errors++; $display("FAIL a_stall_hold got av=%b a=%h dv=%b bp=%b want 1 %h 0 0",
                         bus.a_valid, bus.a_channel, bus.d_valid, bus.backpressureslave, a_beat(3'd0, 8'd12, 32'd77));
    end
    bus.a_ready = 1'b1;
    tick();
    checks++;
    if (bus.d_valid !== 1'b1 || bus.a_valid !== 1'b0 || bus.d_channel !== d_beat(3'd0, 1'b0, 32'd0)) begin
      errors++; $display("FAIL a_stall_release got dv=%b av=%b d=%h want 1 0 %h", bus.d_valid, bus.a_valid, bus.d_channel, d_beat(3'd0, 1'b0, 32'd0));
    end
    tick();
    issue(LD, 32'd12, 32'd0);
    wait_d(ok);
    checks++;
    if (!ok || bus.d_channel !== d_beat(3'd1, 1'b0, 32'd77)) begin
      errors++; $display("FAIL a_stall_readback got ok=%b %h want ok=1 %h", ok, bus.d_channel, d_beat(3'd1, 1'b0, 32'd77));
    end
    tick();
  endtask

  task automatic test_out_of_range();
    bit ok;
    issue(ST, 32'd64, 32'd99);
    wait_d(ok);
    checks++;
    if (!ok || bus.d_error !== 1'b1 || bus.d_channel !== d_beat(3'd0, 1'b1, 32'd0)) begin
      errors++; $display("FAIL oor_store got ok=%b err=%b d=%h want 1 1 %h", ok, bus.d_error, bus.d_channel, d_beat(3'd0, 1'b1, 32'd0));
    end
    tick();
    issue(LD, 32'd0, 32'd0);
    wait_d(ok);
    checks++;
    if (!ok || bus.d_error !== 1'b0 || bus.d_channel !== d_beat(3'd1, 1'b0, 32'd0)) begin
      errors++; $display("FAIL oor_no_alias got ok=%b err=%b d=%h want 1 0 %h", ok, bus.d_error, bus.d_channel, d_beat(3'd1, 1'b0, 32'd0));
    end
    tick();
    issue(LD, 32'd64, 32'd0);
    wait_d(ok);
    checks++;
    if (!ok || bus.d_error !== 1'b1 || bus.d_channel !== d_beat(3'd1, 1'b1, 32'd0)) begin
      errors++; $display("FAIL oor_load got ok=%b err=%b d=%h want 1 1 %h", ok, bus.d_error, bus.d_channel, d_beat(3'd1, 1'b1, 32'd0));
    end
    tick();
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 32'd0 || bus.d_error !== 1'b0) begin
      errors++; $display("FAIL oor_rd got v=%b data=%0d err=%b want 1 0 0", rd_valid, rd_data, bus.d_error);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    issue(LD, 32'd10, 32'd0);
    wait_d(ok);
    tick();
    checks++;
    if (!ok || rd_data !== 32'd30) begin
      errors++; $display("FAIL pre_reset_load got ok=%b data=%0d want 1 30", ok, rd_data);
    end
    issue(LD, 32'd10, 32'd0);
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if ({bus.a_valid, bus.d_valid, bus.d_error, bus.backpressureslave, rd_valid} !== 5'b0 ||
        bus.a_channel !== 53'd0 || bus.d_channel !== 43'd0 || rd_data !== 32'd0) begin
      errors++; $display("FAIL mid_reset got flags=%b a=%h d=%h rd=%h want all 0",
                         {bus.a_valid, bus.d_valid, bus.d_error, bus.backpressureslave, rd_valid}, bus.a_channel, bus.d_channel, rd_data);
    end
    tick();
    reset = 1'b1;
    tick();
    issue(LD, 32'd10, 32'd0);
    wait_d(ok);
    checks++;
    if (!ok || bus.d_channel !== d_beat(3'd1, 1'b0, 32'd0)) begin
      errors++; $display("FAIL post_reset_load got ok=%b %h want ok=1 %h", ok, bus.d_channel, d_beat(3'd1, 1'b0, 32'd0));
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_overwrite();
    test_d_stall();
    test_a_stall();
    test_out_of_range();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
